// File: rtl/boxhead_pkg.sv
// boxhead_pkg: shared health-state type, widths and saturation helper
// Contents:
//   health_state_t  ALIVE / HIT / DEAD
//   BLOOD_W         width of the visible health value
//   ARITH_W         headroom width for saturating arithmetic
//   MAX_NORMAL_C    full health in normal mode
//   MAX_GOD_C       full health in god mode
//   min_w()         unsigned minimum at arithmetic width
package boxhead_pkg;
  typedef enum logic [1:0] {ALIVE, HIT, DEAD} health_state_t;
  localparam int BLOOD_W = 10;
  localparam int ARITH_W = 11;
  localparam int MAX_NORMAL_C = 50;
  localparam int MAX_GOD_C = 300;
  function automatic logic [ARITH_W-1:0] min_w(input logic [ARITH_W-1:0] a, input logic [ARITH_W-1:0] b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/frame_down_counter.sv
// frame_down_counter: loadable down counter decremented on frame ticks
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset, clears the count
//   load_i      load load_val_i (takes priority over tick)
//   load_val_i  value to load
//   tick_i      decrement strobe; the count stops at zero
//   zero_o      count is zero after this cycle's update, so a caller
//               can act on the same tick that brings it to zero
module frame_down_counter #(
  parameter int W = 5
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         tick_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (tick_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  assign zero_o = (cnt_d == '0);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/player_health.sv
// player_health: player hit points, god mode, i-frames and damage handshake
// Ports:
//   Clk             system clock
//   Reset_n         asynchronous active-low reset
//   Frame_Tick      one-Clk strobe per video frame
//   Damage_Req      damage request, held until acked
//   Damage_Amt      damage points, taken on the accepting edge
//   Damage_Ack      one-Clk pulse accepting the current request
//   Heal_Pickup     one-Clk heal strobe
//   Godmode_Toggle  one-Clk god mode flip strobe
//   Respawn         one-Clk respawn strobe
//   Player_Blood    current health, never above the current maximum
//   Godmode_On      god mode active
//   Invincible      high while in HIT
//   Player_Dead     high while in DEAD
// Build option: define PLAYER_HEALTH_REGEN_EN for per-frame regeneration
module player_health
  import boxhead_pkg::*;
#(
  parameter int MAX_NORMAL   = MAX_NORMAL_C,
  parameter int MAX_GOD      = MAX_GOD_C,
  parameter int HEAL_AMT     = 10,
  parameter int IFRAMES      = 30,
  parameter int REGEN_FRAMES = 60
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Frame_Tick,
  input  logic               Damage_Req,
  input  logic [7:0]         Damage_Amt,
  output logic               Damage_Ack,
  input  logic               Heal_Pickup,
  input  logic               Godmode_Toggle,
  input  logic               Respawn,
  output logic [BLOOD_W-1:0] Player_Blood,
  output logic               Godmode_On,
  output logic               Invincible,
  output logic               Player_Dead
);
  localparam int IW = $clog2(IFRAMES + 1);
  health_state_t state_q, state_d;
  logic [BLOOD_W-1:0] blood_q, blood_d;
  logic god_q, god_d, ack_q, inv_q, dead_q;
  logic take, dmg_alive, lethal, tog, resp, iframe_load, iframe_zero, regen_step;
  logic [ARITH_W-1:0] cur_max, cur_blood, dmg_amt, b_dmg, b_heal, b_regen, b_god;
  frame_down_counter #(.W(IW)) u_iframe (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .load_i     (iframe_load),
    .load_val_i (IW'(IFRAMES)),
    .tick_i     (Frame_Tick),
    .zero_o     (iframe_zero)
  );
`ifdef PLAYER_HEALTH_REGEN_EN
  localparam int RW = $clog2(REGEN_FRAMES + 1);
  logic [RW-1:0] regen_q, regen_d;
  logic regen_run, regen_wrap;
  // Counts frames only in ALIVE with no damage this cycle; otherwise parked at zero
  always_comb begin
    regen_run = (state_q == ALIVE) && !dmg_alive;
    regen_wrap = regen_run && Frame_Tick && (regen_q == RW'(REGEN_FRAMES - 1));
    regen_d = !regen_run ? '0 : regen_wrap ? '0 : Frame_Tick ? regen_q + 1'b1 : regen_q;
    regen_step = regen_wrap;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) regen_q <= '0;
    else regen_q <= regen_d;
`else
  assign regen_step = 1'b0;
`endif
  // Same-cycle order: damage, then heal, then regeneration; god mode toggle last
  always_comb begin
    cur_max = god_q ? ARITH_W'(MAX_GOD) : ARITH_W'(MAX_NORMAL);
    cur_blood = ARITH_W'(blood_q);
    dmg_amt = ARITH_W'(Damage_Amt);
    take = Damage_Req && !ack_q;
    dmg_alive = take && (state_q == ALIVE);
    b_dmg = !dmg_alive ? cur_blood : (cur_blood > dmg_amt) ? cur_blood - dmg_amt : '0;
    // Death is decided on the post-damage value, so a same-cycle heal cannot save it
    lethal = dmg_alive && (b_dmg == '0);
    b_heal = (Heal_Pickup && state_q != DEAD && !lethal) ? min_w(b_dmg + ARITH_W'(HEAL_AMT), cur_max) : b_dmg;
    b_regen = regen_step ? min_w(b_heal + 1'b1, cur_max) : b_heal;
    tog = Godmode_Toggle && state_q != DEAD && !lethal;
    b_god = !tog ? b_regen : god_q ? min_w(b_regen, ARITH_W'(MAX_NORMAL)) : ARITH_W'(MAX_GOD);
    god_d = god_q ^ tog;
    resp = Respawn && state_q == DEAD;
    blood_d = BLOOD_W'(resp ? cur_max : b_god);
    iframe_load = dmg_alive && !lethal;
    state_d = resp ? ALIVE : lethal ? DEAD : dmg_alive ? HIT : (state_q == HIT && iframe_zero) ? ALIVE : state_q;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q <= ALIVE;
      blood_q <= BLOOD_W'(MAX_NORMAL);
      god_q <= 1'b0;
      ack_q <= 1'b0;
      inv_q <= 1'b0;
      dead_q <= 1'b0;
    end else begin
      state_q <= state_d;
      blood_q <= blood_d;
      god_q <= god_d;
      ack_q <= take;
      inv_q <= (state_d == HIT);
      dead_q <= (state_d == DEAD);
    end
  assign Damage_Ack = ack_q;
  assign Player_Blood = blood_q;
  assign Godmode_On = god_q;
  assign Invincible = inv_q;
  assign Player_Dead = dead_q;
endmodule

// File: doc/player_health.md
Name: player_health

Overview:
- Owns the player's hit-point value and god-mode flag.
- Feeds the on-screen health bar renderer, which consumes Player_Blood and Godmode_On directly.
- Accepts damage requests from the zombie/bullet collision logic via a req/ack handshake, plus heal pickups and respawn commands from the game controller.
- Runs invincibility frames and per-frame regeneration, all on the system clock gated by a frame strobe.

Parameters:
- MAX_NORMAL, 50, full health in normal mode (five 10-point bar segments).
- MAX_GOD, 300, full health in god mode (three rows of bar).
- HEAL_AMT, 10, points added per Heal_Pickup.
- IFRAMES, 30, frames of invincibility after a damage hit.
- REGEN_FRAMES, 60, frames between +1 regeneration steps.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- Frame_Tick  in  1  one-Clk strobe per video frame
- Damage_Req  in  1  damage request; held high until acked
- Damage_Amt  in  8  damage points; sampled when Damage_Ack is high
- Damage_Ack  out  1  one-Clk pulse accepting the current request
- Heal_Pickup  in  1  one-Clk strobe
- Godmode_Toggle  in  1  one-Clk strobe
- Respawn  in  1  one-Clk strobe
- Player_Blood  out  10  current health, 0..MAX_GOD
- Godmode_On  out  1  god mode active
- Invincible  out  1  high while in HIT state
- Player_Dead  out  1  high while in DEAD state

Behaviour:
- Clock and reset: one clock, Clk; Reset_n is asynchronous and active-low.
- Reset values (all registered outputs):
  - state=ALIVE, Player_Blood=MAX_NORMAL, Godmode_On=0.
  - Damage_Ack=0, Invincible=0, Player_Dead=0.
  - Invincibility counter=0, regeneration counter=0.
- Reset mid-operation returns everything to these values immediately; any pending request is dropped, with no ack.
- Cur_Max = Godmode_On ? MAX_GOD : MAX_NORMAL.
- States:
  - ALIVE: accept damage, regenerate.
  - HIT: invincible; counter loaded with IFRAMES and decremented on Frame_Tick; returns to ALIVE on the tick where the counter reaches 0.
  - DEAD: Player_Blood=0; only Respawn has an effect.
- Damage handshake:
  - When Damage_Req=1 and Damage_Ack=0 in any state, the next Clk asserts Damage_Ack for exactly 1 cycle. Damage_Amt is sampled in that same cycle.
  - Requesters must drop Damage_Req the cycle after the ack; one request yields one ack.
  - In ALIVE, an acked request applies damage: blood = max(blood - Damage_Amt, 0), saturating with no wrap. Result 0 -> DEAD; else -> HIT with counter=IFRAMES.
  - In HIT or DEAD, the request is acked and discarded.
  - Damage_Amt=0 in ALIVE still enters HIT.
- Heal: on Heal_Pickup in ALIVE or HIT, blood = min(blood + HEAL_AMT, Cur_Max). Ignored in DEAD.
- Same-cycle ordering (one Clk): damage, then heal, then regeneration.
  - The death check uses the post-damage value, before heal: lethal damage plus a heal in the same cycle -> DEAD.
  - Damage in a cycle suppresses regeneration and clears the regen counter.
- God mode:
  - Godmode_Toggle in ALIVE/HIT flips Godmode_On.
  - Entering god mode sets blood=MAX_GOD.
  - Leaving god mode sets blood=min(blood, MAX_NORMAL).
  - Ignored in DEAD.
- Respawn: in DEAD -> ALIVE, blood=Cur_Max, counters cleared. Ignored elsewhere.
- Widths: internal arithmetic is 11 bits; Player_Blood never exceeds Cur_Max, so the bar renderer sees no out-of-range value.

Optional Feature:
- Macro: PLAYER_HEALTH_REGEN_EN.
- Defined: in ALIVE only, the regen counter increments on Frame_Tick. At REGEN_FRAMES it wraps to 0 and blood = min(blood+1, Cur_Max). The counter holds at 0 in HIT/DEAD.
- Undefined: no regen counter is instantiated, and blood changes only via damage, heal, god mode and respawn.

Decomposition:
- Shared package boxhead_pkg:
  - typedef enum logic [1:0] health_state_t {ALIVE, HIT, DEAD};
  - constants BLOOD_W=10, MAX_NORMAL_C=50, MAX_GOD_C=300.
- One sub-module, frame_down_counter: load, Frame_Tick-gated decrement, zero flag. Used for i-frames (and reusable for the regen interval).

Test Plan:
- Reset_n pulse low asynchronously mid-HIT -> outputs immediately Blood=50, Godmode_On=0, Invincible=0, Player_Dead=0.
- Blood=50, Damage_Req with Amt=15 -> one Damage_Ack pulse; Blood=35; Invincible=1; a second request during HIT is acked, Blood stays 35; after 30 Frame_Ticks Invincible=0.
- Blood=35, Amt=200 -> Blood=0 (saturated, no wrap); Player_Dead=1; Heal_Pickup ignored; Respawn -> Blood=50, Player_Dead=0.
- Godmode_Toggle -> Godmode_On=1, Blood=300; Heal -> stays 300; toggle again -> Blood=50.
- Same cycle: Blood=5, Amt=5 damage plus Heal_Pickup -> DEAD, Blood=0.
- With PLAYER_HEALTH_REGEN_EN, Blood=48: after 60 ticks Blood=49, after 120 Blood=50, after 180 still 50. Without the macro, Blood stays 48.
